exception_ctrl: RTL

//  Exception/interrupt controller directly upstream of CP0. Collects exception flags from
//  the MEM stage, hardware interrupts and an internal Count/Compare timer, picks one event
//  by fixed priority, and drives CP0's except/pc/cause/state/badAddress capture inputs.
//  It also flushes the pipeline and redirects fetch to the handler vector, or to EPC on ERET.

---
 rtl/exception_ctrl_if.sv | 50 +++++
 rtl/exception_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/exception_ctrl_if.sv
// Signal bundle between the MEM stage / CP0 and the exception controller.
// slave = controller side, master = pipeline/CP0 side.
interface exception_ctrl_if #(
   parameter int unsigned TIMER_W = 32
);
   logic [5:0]         int_hw;
   logic [31:0]        status_in;
   logic [31:0]        epc_in;
   logic               mem_valid;
   logic [31:0]        mem_pc;
   logic               mem_bd;
   logic [31:0]        mem_addr;
   logic               exc_if_adel;
   logic               exc_ri;
   logic               exc_sys;
   logic               exc_bp;
   logic               exc_ov;
   logic               exc_adel;
   logic               exc_ades;
   logic               eret;
   logic               cmp_wr;
   logic [TIMER_W-1:0] cmp_data;

   logic               except;
   logic [31:0]        pc;
   logic [31:0]        cause;
   logic [31:0]        state;
   logic [31:0]        badAddress;
   logic               flush;
   logic               redirect_valid;
   logic [31:0]        redirect_pc;
   logic [TIMER_W-1:0] count_out;
   logic               busy;

   modport slave (
      input  int_hw, status_in, epc_in, mem_valid, mem_pc, mem_bd, mem_addr,
             exc_if_adel, exc_ri, exc_sys, exc_bp, exc_ov, exc_adel, exc_ades,
             eret, cmp_wr, cmp_data,
      output except, pc, cause, state, badAddress, flush, redirect_valid,
             redirect_pc, count_out, busy
   );

   modport master (
      output int_hw, status_in, epc_in, mem_valid, mem_pc, mem_bd, mem_addr,
             exc_if_adel, exc_ri, exc_sys, exc_bp, exc_ov, exc_adel, exc_ades,
             eret, cmp_wr, cmp_data,
      input  except, pc, cause, state, badAddress, flush, redirect_valid,
             redirect_pc, count_out, busy
   );
endinterface

// File: rtl/exception_ctrl.sv
// Exception/interrupt controller feeding CP0: prioritises MEM-stage exceptions,
// hardware and timer interrupts, and sequences capture, flush and fetch redirect.
module exception_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0380,
   parameter int unsigned TIMER_W    = 32
) (
   input  logic clk_i,
   input  logic rst_i,
   exception_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_TRAP     = 2'd1,
      S_REDIRECT = 2'd2
   } state_e;

   state_e             fsm_q;
   logic               tog_q;
   logic [TIMER_W-1:0] count_q;
   logic [TIMER_W-1:0] compare_q;
   logic               timer_pend_q;

   logic               except_q;
   logic               flush_q;
   logic               redirect_valid_q;
   logic               busy_q;
   logic [31:0]        epc_q;
   logic [31:0]        cause_q;
   logic [31:0]        status_q;
   logic [31:0]        bad_addr_q;
   logic [31:0]        redirect_pc_q;

   logic [7:0]         ip_c;
   logic               int_take_c;
   logic               exc_take_d;
   logic [4:0]         exc_code_d;
   logic [31:0]        bad_addr_d;
   logic [31:0]        epc_d;
   logic [31:0]        cause_d;

   // Event selection: fixed priority, interrupt first, nothing without a valid MEM instruction.
   always_comb begin
      ip_c       = {bus.int_hw[5] | timer_pend_q, bus.int_hw[4:0], 2'b00};
      int_take_c = (|(ip_c & bus.status_in[15:8])) & bus.status_in[0] & ~bus.status_in[1];
      exc_take_d = bus.mem_valid;
      exc_code_d = 5'd0;
      bad_addr_d = 32'd0;
      if (int_take_c) begin
         exc_code_d = 5'd0;
      end else if (bus.exc_if_adel) begin
         exc_code_d = 5'd4;
         bad_addr_d = bus.mem_pc;
      end else if (bus.exc_ri) begin
         exc_code_d = 5'd10;
      end else if (bus.exc_sys) begin
         exc_code_d = 5'd8;
      end else if (bus.exc_bp) begin
         exc_code_d = 5'd9;
      end else if (bus.exc_ov) begin
         exc_code_d = 5'd12;
      end else if (bus.exc_adel) begin
         exc_code_d = 5'd4;
         bad_addr_d = bus.mem_addr;
      end else if (bus.exc_ades) begin
         exc_code_d = 5'd5;
         bad_addr_d = bus.mem_addr;
      end else begin
         exc_take_d = 1'b0;
      end
      epc_d   = bus.mem_bd ? (bus.mem_pc - 32'd4) : bus.mem_pc;
      cause_d = {bus.mem_bd, timer_pend_q, 14'd0, ip_c, 1'b0, exc_code_d, 2'b00};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fsm_q            <= S_IDLE;
         tog_q            <= 1'b0;
         count_q          <= '0;
         compare_q        <= '0;
         timer_pend_q     <= 1'b0;
         except_q         <= 1'b0;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         busy_q           <= 1'b0;
         epc_q            <= 32'd0;
         cause_q          <= 32'd0;
         status_q         <= 32'd0;
         bad_addr_q       <= 32'd0;
         redirect_pc_q    <= 32'd0;
      end else begin
         // Count advances on every second clock; a Compare write beats a match in the same cycle.
         tog_q <= ~tog_q;
         if (tog_q) count_q <= count_q + TIMER_W'(1);
         if (bus.cmp_wr) begin
            compare_q    <= bus.cmp_data;
            timer_pend_q <= 1'b0;
         end else if ((count_q == compare_q) && (compare_q != '0)) begin
            timer_pend_q <= 1'b1;
         end

         except_q         <= 1'b0;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;

         unique case (fsm_q)
            S_IDLE: begin
               if (exc_take_d) begin
                  fsm_q      <= S_TRAP;
                  busy_q     <= 1'b1;
                  except_q   <= 1'b1;
                  flush_q    <= 1'b1;
                  epc_q      <= epc_d;
                  cause_q    <= cause_d;
                  status_q   <= bus.status_in | 32'h0000_0002;
                  bad_addr_q <= bad_addr_d;
               end else if (bus.mem_valid && bus.eret) begin
                  redirect_valid_q <= 1'b1;
                  flush_q          <= 1'b1;
                  redirect_pc_q    <= bus.epc_in;
               end
            end
            S_TRAP: begin
               fsm_q            <= S_REDIRECT;
               redirect_valid_q <= 1'b1;
               redirect_pc_q    <= EXC_VECTOR;
            end
            S_REDIRECT: begin
               fsm_q  <= S_IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               fsm_q  <= S_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.except         = except_q;
   assign bus.pc             = epc_q;
   assign bus.cause          = cause_q;
   assign bus.state          = status_q;
   assign bus.badAddress     = bad_addr_q;
   assign bus.flush          = flush_q;
   assign bus.redirect_valid = redirect_valid_q;
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.count_out      = count_q;
   assign bus.busy           = busy_q;

endmodule
